chan_mux_seq: RTL and testbench

- Parametrised, clocked successor to the team's per-bit 2:1 nibble selector.
- Selects one of NCH input channels, each WIDTH bits wide, and registers the chosen channel onto dout.
- Three modes: manual select, auto-scan (round-robin rotation with a programmable dwell time), and hold (output frozen).
- Sits between the pad-level input buses and the output bus of a tile top; glue logic packs ui_in/uio_in into din.

---
 rtl/chan_mux_pkg.sv | 18 +
 rtl/chan_mux_scan_ctrl.sv | 77 +++++++
 rtl/chan_mux_seq.sv | 85 ++++++++
 tb/tb_chan_mux_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_mux_pkg.sv
// Shared mode encodings for the channel mux and its scan controller.
// No timing of its own.
// No flow control of its own.
package chan_mux_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_MANUAL = 2'b00;
    localparam mode_t MODE_SCAN   = 2'b01;
    localparam mode_t MODE_HOLD   = 2'b10;

    // Encoding 2'b11 is reserved and treated exactly like hold, so any mode
    // with the top bit set freezes the selector and the output register.
    function automatic logic is_hold(input mode_t m);
        return m[1];
    endfunction

endpackage

// File: rtl/chan_mux_scan_ctrl.sv
// Channel-index controller: manual load, round-robin scan with dwell, hold.
// cur_sel updates on the edge that samples sel_load or the dwell match.
// No backpressure; ena=0 freezes all state and forces scan_wrap low.
module chan_mux_scan_ctrl
    import chan_mux_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DWELL_W = 4,
    parameter int SEL_W   = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  mode_t              mode,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic               sel_load,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               scan_wrap,
    output logic               sel_err
);

    localparam logic [SEL_W:0]   NCH_V    = (SEL_W+1)'(NCH);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NCH - 1);

    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;

    // Next-state: load beats scan advance; the counter simply rolls over
    // when dwell is lowered below it, so it never needs saturation logic.
    always_comb begin
        cnt_d  = cnt_q;
        sel_d  = sel_q;
        wrap_d = 1'b0;
        err_d  = err_q;
        if (ena) begin
            if (sel_load && !is_hold(mode)) begin
                if ({1'b0, sel_in} < NCH_V) begin
                    sel_d = sel_in;
                    cnt_d = '0;
                end else begin
                    err_d = 1'b1;
                end
            end else if (mode == MODE_SCAN && cnt_q == dwell) begin
                cnt_d  = '0;
                sel_d  = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
                wrap_d = (sel_q == LAST_SEL);
            end else if (mode == MODE_SCAN) begin
                cnt_d = cnt_q + 1'b1;
            end else if (mode == MODE_MANUAL) begin
                cnt_d = '0;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sel_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign cur_sel   = sel_q;
    assign scan_wrap = wrap_q;
    assign sel_err   = err_q;

endmodule

// File: rtl/chan_mux_seq.sv
// Registered NCH:1 channel selector with manual, auto-scan and hold modes.
// din to dout is 1 cycle; a new cur_sel shows on dout one edge later.
// No backpressure; ena=0 freezes dout, dout_valid and the selector.
module chan_mux_seq
    import chan_mux_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NCH     = 4,
    parameter int DWELL_W = 4,
    parameter int SEL_W   = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic [1:0]           mode,
    input  logic [SEL_W-1:0]     sel_in,
    input  logic                 sel_load,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    output logic [SEL_W-1:0]     cur_sel,
    output logic                 scan_wrap,
    output logic                 sel_err
);

    mode_t            mode_w;
    logic [WIDTH-1:0] sel_dat;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;

    assign mode_w = mode_t'(mode);

    chan_mux_scan_ctrl #(
        .NCH     (NCH),
        .DWELL_W (DWELL_W),
        .SEL_W   (SEL_W)
    ) u_scan_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .mode      (mode_w),
        .sel_in    (sel_in),
        .sel_load  (sel_load),
        .dwell     (dwell),
        .cur_sel   (cur_sel),
        .scan_wrap (scan_wrap),
        .sel_err   (sel_err)
    );

    // Channel mux driven by the registered index, so dout lags cur_sel by one edge.
    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < NCH; k++) begin
            if (cur_sel == SEL_W'(k)) begin
                sel_dat = din[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output register loads whenever enabled and not holding; valid is sticky.
    always_comb begin
        dout_d = dout_q;
        vld_d  = vld_q;
        if (ena && !is_hold(mode_w)) begin
            dout_d = sel_dat;
            vld_d  = 1'b1;
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            vld_q  <= vld_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = vld_q;

endmodule

// File: tb/tb_chan_mux_seq.sv
// Directed bench for chan_mux_seq: NCH=4 main instance plus an NCH=3 instance
// for the out-of-range load path. Outputs are sampled 1 time unit after the
// rising edge; inputs change at that same point.
module tb_chan_mux_seq;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [3:0]  dwell;

    logic [15:0] din;
    logic [1:0]  mode;
    logic [1:0]  sel_in;
    logic        sel_load;
    logic [3:0]  dout;
    logic        dout_valid;
    logic [1:0]  cur_sel;
    logic        scan_wrap;
    logic        sel_err;

    logic [11:0] din3;
    logic [1:0]  mode3;
    logic [1:0]  sel_in3;
    logic        sel_load3;
    logic [3:0]  dout3;
    logic        dout_valid3;
    logic [1:0]  cur_sel3;
    logic        scan_wrap3;
    logic        sel_err3;

    int checks;
    int errors;

    chan_mux_seq #(.WIDTH(4), .NCH(4), .DWELL_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .din        (din),
        .mode       (mode),
        .sel_in     (sel_in),
        .sel_load   (sel_load),
        .dwell      (dwell),
        .dout       (dout),
        .dout_valid (dout_valid),
        .cur_sel    (cur_sel),
        .scan_wrap  (scan_wrap),
        .sel_err    (sel_err)
    );

    chan_mux_seq #(.WIDTH(4), .NCH(3), .DWELL_W(4)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .din        (din3),
        .mode       (mode3),
        .sel_in     (sel_in3),
        .sel_load   (sel_load3),
        .dwell      (dwell),
        .dout       (dout3),
        .dout_valid (dout_valid3),
        .cur_sel    (cur_sel3),
        .scan_wrap  (scan_wrap3),
        .sel_err    (sel_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; dwell = 4'd0;
        din = 16'hDCBA; mode = 2'b00; sel_in = 2'd0; sel_load = 1'b0;
        din3 = 12'h987; mode3 = 2'b00; sel_in3 = 2'd0; sel_load3 = 1'b0;
        step(); step();
        checks++;
        if ({dout, dout_valid, cur_sel, scan_wrap, sel_err} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got dout=%h vld=%b sel=%0d wrap=%b err=%b, want all 0",
                     dout, dout_valid, cur_sel, scan_wrap, sel_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_manual();
        mode = 2'b00; sel_in = 2'd2; sel_load = 1'b1;
        step();
        sel_load = 1'b0;
        checks++;
        if (cur_sel !== 2'd2) begin
            errors++; $display("FAIL manual_load_sel: got %0d want 2", cur_sel);
        end
        checks++;
        if (dout !== 4'hA || dout_valid !== 1'b1) begin
            errors++; $display("FAIL manual_first_dout: got %h/%b want a/1", dout, dout_valid);
        end
        step();
        checks++;
        if (dout !== 4'hC) begin
            errors++; $display("FAIL manual_dout_ch2: got %h want c", dout);
        end
    endtask

    task automatic test_sel_err();
        mode3 = 2'b00; sel_in3 = 2'd2; sel_load3 = 1'b1;
        step();
        checks++;
        if (cur_sel3 !== 2'd2 || sel_err3 !== 1'b0) begin
            errors++; $display("FAIL nch3_valid_load: got sel=%0d err=%b want 2/0", cur_sel3, sel_err3);
        end
        sel_in3 = 2'd3;
        step();
        checks++;
        if (cur_sel3 !== 2'd2 || sel_err3 !== 1'b1) begin
            errors++; $display("FAIL nch3_bad_load: got sel=%0d err=%b want 2/1", cur_sel3, sel_err3);
        end
        checks++;
        if (dout3 !== 4'h9) begin
            errors++; $display("FAIL nch3_dout: got %h want 9", dout3);
        end
        sel_in3 = 2'd0;
        step();
        sel_load3 = 1'b0;
        checks++;
        if (cur_sel3 !== 2'd0 || sel_err3 !== 1'b1) begin
            errors++; $display("FAIL nch3_err_sticky: got sel=%0d err=%b want 0/1", cur_sel3, sel_err3);
        end
    endtask

    task automatic test_scan();
        logic [1:0] exp_sel [12];
        exp_sel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
        mode = 2'b01; dwell = 4'd2; sel_in = 2'd0; sel_load = 1'b1;
        step();
        sel_load = 1'b0;
        checks++;
        if (cur_sel !== 2'd0) begin
            errors++; $display("FAIL scan_start: got %0d want 0", cur_sel);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (cur_sel !== exp_sel[i] || scan_wrap !== (i == 11)) begin
                errors++;
                $display("FAIL scan_seq[%0d]: got sel=%0d wrap=%b want %0d/%b",
                         i, cur_sel, scan_wrap, exp_sel[i], (i == 11));
            end
        end
        step();
        checks++;
        if (scan_wrap !== 1'b0) begin
            errors++; $display("FAIL scan_wrap_one_cycle: got %b want 0", scan_wrap);
        end
    endtask

    task automatic test_load_priority();
        mode = 2'b01; dwell = 4'd0; sel_in = 2'd1; sel_load = 1'b1;
        step();
        step();
        sel_load = 1'b0;
        checks++;
        if (cur_sel !== 2'd1) begin
            errors++; $display("FAIL load_beats_advance: got %0d want 1", cur_sel);
        end
        step(); step(); step();
        checks++;
        if (cur_sel !== 2'd0 || scan_wrap !== 1'b1) begin
            errors++; $display("FAIL dwell0_wrap: got sel=%0d wrap=%b want 0/1", cur_sel, scan_wrap);
        end
    endtask

    task automatic test_dwell_lower();
        int early;
        early = 0;
        mode = 2'b01; dwell = 4'd3; sel_in = 2'd0; sel_load = 1'b1;
        step();
        sel_load = 1'b0;
        step(); step();
        dwell = 4'd1;
        for (int i = 0; i < 15; i++) begin
            step();
            if (cur_sel !== 2'd0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL dwell_lower_hold: advanced early in %0d cycles, want 0", early);
        end
        step();
        checks++;
        if (cur_sel !== 2'd1) begin
            errors++; $display("FAIL dwell_lower_advance: got %0d want 1", cur_sel);
        end
    endtask

    task automatic test_manual_clear();
        mode = 2'b01; dwell = 4'd3; sel_in = 2'd0; sel_load = 1'b1;
        step();
        sel_load = 1'b0;
        step(); step();
        mode = 2'b00;
        step();
        mode = 2'b01;
        step(); step(); step();
        checks++;
        if (cur_sel !== 2'd0) begin
            errors++; $display("FAIL manual_clears_cnt: got %0d want 0", cur_sel);
        end
        step();
        checks++;
        if (cur_sel !== 2'd1) begin
            errors++; $display("FAIL manual_clear_advance: got %0d want 1", cur_sel);
        end
    endtask

    task automatic test_hold();
        mode = 2'b01; dwell = 4'd3; sel_in = 2'd0; sel_load = 1'b1;
        step();
        sel_load = 1'b0;
        step(); step();
        mode = 2'b10; din = 16'h1234; sel_in = 2'd3; sel_load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (cur_sel !== 2'd0 || dout !== 4'hA || sel_err !== 1'b0) begin
                errors++;
                $display("FAIL hold_frozen[%0d]: got sel=%0d dout=%h err=%b want 0/a/0",
                         i, cur_sel, dout, sel_err);
            end
        end
        mode = 2'b11;
        step();
        checks++;
        if (cur_sel !== 2'd0 || dout !== 4'hA) begin
            errors++; $display("FAIL reserved_is_hold: got sel=%0d dout=%h want 0/a", cur_sel, dout);
        end
        mode = 2'b01; sel_load = 1'b0;
        step();
        checks++;
        if (cur_sel !== 2'd0 || dout !== 4'h4) begin
            errors++; $display("FAIL hold_resume1: got sel=%0d dout=%h want 0/4", cur_sel, dout);
        end
        step();
        checks++;
        if (cur_sel !== 2'd1) begin
            errors++; $display("FAIL hold_resume2: got %0d want 1", cur_sel);
        end
    endtask

    task automatic test_async_reset();
        int moved;
        moved = 0;
        mode = 2'b01; dwell = 4'd1;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dout, dout_valid, cur_sel, scan_wrap, sel_err} !== 9'b0) begin
            errors++;
            $display("FAIL async_reset: got dout=%h vld=%b sel=%0d wrap=%b err=%b, want all 0",
                     dout, dout_valid, cur_sel, scan_wrap, sel_err);
        end
        ena = 1'b0; dwell = 4'd0; sel_in = 2'd2; sel_load = 1'b1;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if ({dout, dout_valid, cur_sel, scan_wrap} !== 8'b0) moved++;
        end
        checks++;
        if (moved != 0) begin
            errors++; $display("FAIL ena_low_frozen: changed in %0d cycles, want 0", moved);
        end
        ena = 1'b1;
        step();
        sel_load = 1'b0;
        checks++;
        if (cur_sel !== 2'd2 || dout !== 4'h4 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL ena_resume: got sel=%0d dout=%h vld=%b want 2/4/1", cur_sel, dout, dout_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_manual();
        test_sel_err();
        test_scan();
        test_load_priority();
        test_dwell_lower();
        test_manual_clear();
        test_hold();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
